ram_io_responder: RTL and testbench

- Responder end of the memory controller's byte-serial RAM interface: single-port byte RAM plus a memory-mapped IO window.
- One byte per cycle. Read data is registered and appears the cycle after its address.
- IO window: TX byte FIFO drained by a host handshake, RX byte FIFO filled by the host, and a status register.
- Drives the io_buffer_full back-pressure flag seen by the memory controller.

---
 rtl/ram_io_responder_pkg.sv | 28 ++
 rtl/ram_io_responder_fifo.sv | 65 ++++++
 rtl/ram_io_responder.sv | 141 ++++++++++++++
 tb/tb_ram_io_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared constants and the IO address decoder for the
// byte-serial RAM/IO responder.
package ram_io_responder_pkg;

  localparam logic [31:0] IO_BASE     = 32'h30000;
  localparam logic [15:0] IO_DATA_OFF = 16'h0000;
  localparam logic [15:0] IO_STAT_OFF = 16'h0004;
  localparam logic [1:0]  IO_SEL      = 2'b11;

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_DATA,
    ACC_STAT,
    ACC_NONE
  } acc_e;

  function automatic acc_e io_decode(
    input logic [31:0] a
  );
    logic [15:0] off;
    off = a[15:0] - IO_BASE[15:0];
    if (a[17:16] != IO_SEL) return ACC_RAM;
    if (off == IO_DATA_OFF) return ACC_DATA;
    if (off == IO_STAT_OFF) return ACC_STAT;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// Byte FIFO with power-of-two depth; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign pop_ok  = en && pop && !empty;
  assign push_ok = en && push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus TX/RX FIFO IO window behind the controller bus.
// Define RAM_WRITE_GUARD_EN to block RAM writes below PROTECT_TOP.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 17,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FULL_MARGIN = 2,
  parameter logic [31:0] PROTECT_TOP = 32'h1000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] addr,
  input  logic        is_write,
  input  logic [7:0]  write,
  output logic [7:0]  read,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        halt,
  output logic        err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            ram_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [7:0]            read_q, read_d;
  logic                  halt_q, halt_d;
  acc_e                  acc;
  logic                  below_top, blocked, ram_we;

  logic          tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;
  logic          rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [CW-1:0] unused_rx_count;

  assign acc       = io_decode(addr);
  assign ram_idx   = addr[ADDR_WIDTH-1:0];
  assign below_top = (addr < PROTECT_TOP);

`ifdef RAM_WRITE_GUARD_EN
  logic err_q, err_d;
  assign blocked = below_top;
  assign err_d   = err_q | (rdy_in && is_write
                   && acc == ACC_RAM && below_top);
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) err_q <= 1'b0;
    else           err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_guard;
  assign unused_guard = below_top;
  assign blocked      = 1'b0;
  assign err          = 1'b0;
`endif

  assign ram_we = rdy_in && is_write
                  && acc == ACC_RAM && !blocked;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_idx] <= write;
  end

  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .en    (rdy_in),
    .push  (is_write && acc == ACC_DATA),
    .pop   (tx_ready),
    .din   (write),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // RX only takes a byte the host saw rx_ready for
  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .en    (rdy_in),
    .push  (rx_valid && !rx_full),
    .pop   (!is_write && acc == ACC_DATA),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (unused_rx_count)
  );

  always_comb begin
    read_d = read_q;
    halt_d = halt_q;
    if (rdy_in) begin
      unique case (acc)
        ACC_RAM: begin
          read_d = (is_write && !blocked) ? write
                                          : ram_q[ram_idx];
        end
        ACC_DATA: begin
          if (!is_write) read_d = rx_empty ? 8'h00 : rx_dout;
        end
        ACC_STAT: begin
          if (!is_write) read_d = {6'b0, !rx_empty, tx_full};
          else           halt_d = 1'b1;
        end
        ACC_NONE: begin
          if (!is_write) read_d = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      read_q <= 8'h00;
      halt_q <= 1'b0;
    end else begin
      read_q <= read_d;
      halt_q <= halt_d;
    end
  end

  assign read           = read_q;
  assign halt           = halt_q;
  assign tx_valid       = !tx_empty;
  assign tx_data        = tx_empty ? 8'h00 : tx_dout;
  assign rx_ready       = !rx_full;
  assign io_buffer_full = (CW'(FIFO_DEPTH) - tx_count)
                          <= CW'(FULL_MARGIN);

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench: a queue/array model predicts every cycle,
// monitors compare DUT outputs and the TX byte stream.
module tb_ram_io_responder;

  localparam int          DEPTH  = 8;
  localparam int          MARGIN = 2;
  localparam logic [31:0] PTOP   = 32'h1000;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] addr = '0;
  logic        is_write = 1'b0;
  logic [7:0]  write = '0;
  logic [7:0]  read;
  logic        io_buffer_full, tx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        halt, err;

  ram_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .addr(addr), .is_write(is_write), .write(write),
    .read(read), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .halt(halt), .err(err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] rd;
    bit         chk;
    bit         ibf, hlt, er, rxr, txv;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] txexp[$];
  logic [7:0] txm[$];
  logic [7:0] rxm[$];
  logic [7:0] mem_m[int];
  logic [7:0] m_rd = 8'h00;
  bit         m_known = 1'b1;
  bit         m_halt = 1'b0;
  bit         m_err = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t",
               nm, act, ex, $time);
    end
  endtask

  function automatic bit guarded(input logic [31:0] a);
`ifdef RAM_WRITE_GUARD_EN
    return a < PTOP;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Model of one bus cycle; inputs applied now, effects at next edge
  task automatic drive(input logic [31:0] a, input bit we,
                       input logic [7:0] wd, input bit txr,
                       input bit rxv, input logic [7:0] rxd,
                       input bit rdy);
    exp_t e;
    bit io, tpop, tpush, rpush, rxne, txf;
    logic [15:0] off;
    int idx;
    addr = a; is_write = we; write = wd;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd; rdy_in = rdy;
    if (rdy) begin
      io    = (a[17:16] == 2'b11);
      off   = a[15:0];
      idx   = int'(a & 32'h1FFFF);
      rxne  = rxm.size() > 0;
      txf   = txm.size() == DEPTH;
      tpop  = (txm.size() > 0) && txr;
      rpush = rxv && (rxm.size() < DEPTH);
      tpush = 1'b0;
      if (!io && we) begin
        if (guarded(a)) begin
          m_err = 1'b1;
          m_known = mem_m.exists(idx);
          if (m_known) m_rd = mem_m[idx];
        end else begin
          mem_m[idx] = wd; m_rd = wd; m_known = 1'b1;
        end
      end else if (!io) begin
        m_known = mem_m.exists(idx);
        if (m_known) m_rd = mem_m[idx];
      end else if (we) begin
        if (off == 16'h0) tpush = (txm.size() < DEPTH) || tpop;
        else if (off == 16'h4) m_halt = 1'b1;
      end else begin
        m_known = 1'b1;
        if (off == 16'h0) m_rd = rxne ? rxm.pop_front() : 8'h00;
        else if (off == 16'h4) m_rd = {6'b0, rxne, txf};
        else m_rd = 8'h00;
      end
      if (tpop) void'(txm.pop_front());
      if (tpush) begin txm.push_back(wd); txexp.push_back(wd); end
      if (rpush) rxm.push_back(rxd);
    end
    e.rd  = m_rd;
    e.chk = m_known;
    e.ibf = (DEPTH - txm.size()) <= MARGIN;
    e.hlt = m_halt;
    e.er  = m_err;
    e.rxr = rxm.size() < DEPTH;
    e.txv = txm.size() > 0;
    exp_q.push_back(e);
    @(negedge clk_in);
  endtask

  task automatic idle_rd(input bit txr);
    drive(32'h00040, 1'b0, 8'h00, txr, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin : mon_cycle
    exp_t e;
    forever begin
      @(posedge clk_in); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) chk("read", read, e.rd);
        chk("io_buffer_full", io_buffer_full, e.ibf);
        chk("halt", halt, e.hlt);
        chk("err", err, e.er);
        chk("rx_ready", rx_ready, e.rxr);
        chk("tx_valid", tx_valid, e.txv);
      end
    end
  end

  initial begin : mon_tx
    forever begin
      @(negedge clk_in); #4;
      if (rst_n_in && rdy_in && tx_valid && tx_ready) begin
        if (txexp.size() == 0)
          chk("tx_unexpected", tx_data, 32'hFFFF);
        else
          chk("tx_data", tx_data, txexp.pop_front());
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_read", read, 0);
    chk("rst_ibf", io_buffer_full, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_halt", halt, 0);
    chk("rst_err", err, 0);
  endtask

  logic [31:0] pool [12] = '{
    32'h00040, 32'h00010, 32'h20010, 32'h01234, 32'h1FFFF,
    32'h0FFF0, 32'h30000, 32'h30004, 32'h30008, 32'h3FFF0,
    32'h70000, 32'h30000
  };

  initial begin : stim
    int n;
    #23;
    chk_reset_outputs();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    drive(32'h00040, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
    idle_rd(1'b0);

    for (int i = 0; i < 9; i++)
      drive(32'h30000, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) idle_rd(1'b1);

    drive(32'h00040, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1);
    drive(32'h00040, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 1'b1);
    drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++)
      drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++)
      drive(32'h30000, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h30000, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b1);
    drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) idle_rd(1'b1);

    drive(32'h00010, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h20010, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h00010, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h30004, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h30000, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_rd(1'b0);

    for (int i = 0; i < 400; i++) begin
      n = int'($urandom_range(11));
      drive(pool[n], 1'($urandom_range(1)), 8'($urandom),
            1'($urandom_range(1)), 1'($urandom_range(1)),
            8'($urandom), $urandom_range(9) != 0);
    end

    drive(32'h30000, 1'b1, 8'hC1, 1'b0, 1'b1, 8'hD2, 1'b1);
    drive(32'h00040, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk_in); #3;
    rst_n_in = 1'b0;
    #1;
    chk_reset_outputs();
    txm.delete(); rxm.delete(); txexp.delete();
    m_rd = 8'h00; m_known = 1'b1; m_halt = 1'b0; m_err = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(32'h20010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    idle_rd(1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk_in);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
